// File: rtl/du_ras_if.sv
// du_ras_if: bundles the dispatch, RAS, prediction, CDB-resolution and
// status signals of the dispatch-side RAS controller.
//   master : environment side (fetch/decode, RAS, CDB); drives the
//            instruction, the RAS top-of-stack and the CDB resolution.
//   slave  : du_ras_ctrl side; drives stall, push/pop strobes, the
//            prediction, flush/redirect and the status counters.
interface du_ras_if #(
  parameter int RAS_WIDTH = 32,
  parameter int TAG_W     = 2,
  parameter int CNT_W     = 16
);
  logic                 if_valid;
  logic [RAS_WIDTH-1:0] if_pc;
  logic                 if_is_jal;
  logic                 if_is_jr31;
  logic                 du_stall;
  logic                 du_jal_push;
  logic [RAS_WIDTH-1:0] du_jal_push_din;
  logic                 du_jr31_pop;
  logic [RAS_WIDTH-1:0] du_jr31_pop_dout;
  logic                 du_jr31_pred_valid;
  logic [RAS_WIDTH-1:0] du_jr31_pred_target;
  logic [TAG_W-1:0]     du_jr31_pred_tag;
  logic                 cdb_jr31_valid;
  logic [TAG_W-1:0]     cdb_jr31_tag;
  logic [RAS_WIDTH-1:0] cdb_jr31_target;
  logic                 du_flush;
  logic [RAS_WIDTH-1:0] du_flush_target;
  logic [TAG_W:0]       du_pending_cnt;
  logic [CNT_W-1:0]     du_mispred_cnt;

  modport master (
    output if_valid, if_pc, if_is_jal, if_is_jr31, du_jr31_pop_dout,
           cdb_jr31_valid, cdb_jr31_tag, cdb_jr31_target,
    input  du_stall, du_jal_push, du_jal_push_din, du_jr31_pop,
           du_jr31_pred_valid, du_jr31_pred_target, du_jr31_pred_tag,
           du_flush, du_flush_target, du_pending_cnt, du_mispred_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_is_jal, if_is_jr31, du_jr31_pop_dout,
           cdb_jr31_valid, cdb_jr31_tag, cdb_jr31_target,
    output du_stall, du_jal_push, du_jal_push_din, du_jr31_pop,
           du_jr31_pred_valid, du_jr31_pred_target, du_jr31_pred_tag,
           du_flush, du_flush_target, du_pending_cnt, du_mispred_cnt
  );
endinterface

// File: rtl/du_ras_ctrl.sv
// du_ras_ctrl: dispatch-side return-address-stack controller.
//   jal     -> pushes if_pc+4 onto the RAS in the accept cycle.
//   jr $31  -> pops the RAS, forwards the popped address to fetch as the
//              predicted target and records it in a tagged pending table.
//   CDB     -> compares the actual target with the recorded one; a
//              mismatch raises a one-cycle registered flush/redirect and
//              clears the whole table.
// Ports: clk, reset (sync, active-high), bus (du_ras_if.slave).
module du_ras_ctrl #(
  parameter int RAS_WIDTH  = 32,
  parameter int PRED_DEPTH = 4,
  parameter int TAG_W      = $clog2(PRED_DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic      clk,
  input  logic      reset,
  du_ras_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [PRED_DEPTH-1:0] busy_p0;
  logic [PRED_DEPTH-1:0] busy_nxt;
  logic [RAS_WIDTH-1:0]  target_p0 [PRED_DEPTH];
  logic [TAG_W-1:0]      alloc_ptr_p0;
  logic                  flush_p1;
  logic [RAS_WIDTH-1:0]  flush_target_p1;
  logic [CNT_W-1:0]      mispred_cnt_p1;
  logic [TAG_W:0]        pending_cnt;

  logic is_jr;
  logic stall;
  logic accept;
  logic pop;
  logic cdb_hit;
  logic mispred;

  // ---- stage 0: dispatch decision and CDB check (combinational) ----
  // jal wins when both flags are set, so only a pure jr $31 allocates.
  assign is_jr   = bus.if_valid & bus.if_is_jr31 & ~bus.if_is_jal;
  // Stall on registered busy: a slot freed this cycle helps next cycle.
  assign stall   = ~reset & (flush_p1 | (is_jr & busy_p0[alloc_ptr_p0]));
  assign accept  = bus.if_valid & ~stall & ~reset;
  assign pop     = accept & is_jr;
  // Resolutions landing in the flush cycle refer to an already-cleared table.
  assign cdb_hit = bus.cdb_jr31_valid & busy_p0[bus.cdb_jr31_tag] & ~flush_p1;
  assign mispred = cdb_hit & (bus.cdb_jr31_target != target_p0[bus.cdb_jr31_tag]);

  assign bus.du_stall            = stall;
  assign bus.du_jal_push         = accept & bus.if_is_jal;
  assign bus.du_jal_push_din     = bus.if_pc + RAS_WIDTH'(4);
  assign bus.du_jr31_pop         = pop;
  assign bus.du_jr31_pred_valid  = pop;
  assign bus.du_jr31_pred_target = bus.du_jr31_pop_dout;
  assign bus.du_jr31_pred_tag    = alloc_ptr_p0;
  assign bus.du_flush            = flush_p1;
  assign bus.du_flush_target     = flush_target_p1;
  assign bus.du_pending_cnt      = pending_cnt;
  assign bus.du_mispred_cnt      = mispred_cnt_p1;

  // Allocation and resolution never target the same slot (one needs it
  // free, the other busy); a mispredict clear overrides both.
  always_comb begin
    busy_nxt = busy_p0;
    if (pop)     busy_nxt[alloc_ptr_p0] = 1'b1;
    if (cdb_hit) busy_nxt[bus.cdb_jr31_tag] = 1'b0;
    if (mispred) busy_nxt = '0;
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < PRED_DEPTH; i++)
      pending_cnt = pending_cnt + (TAG_W+1)'(busy_p0[i]);
  end

  // ---- stage 1: table, pointer, flush and statistics registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_p0         <= '0;
      alloc_ptr_p0    <= '0;
      flush_p1        <= 1'b0;
      flush_target_p1 <= '0;
      mispred_cnt_p1  <= '0;
    end else begin
      busy_p0  <= busy_nxt;
      flush_p1 <= mispred;
      if (mispred) begin
        flush_target_p1 <= bus.cdb_jr31_target;
        mispred_cnt_p1  <= sat_inc(mispred_cnt_p1);
        alloc_ptr_p0    <= '0;
      end else if (pop) begin
        alloc_ptr_p0 <= alloc_ptr_p0 + TAG_W'(1);
      end
    end
  end

  // Target payload is only meaningful while its busy bit is set.
  always_ff @(posedge clk) begin
    if (pop) target_p0[alloc_ptr_p0] <= bus.du_jr31_pop_dout;
  end

endmodule

// File: tb/tb_du_ras_ctrl.sv
module tb_du_ras_ctrl;
  localparam int RW = 32;
  localparam int PD = 4;
  localparam int TW = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  du_ras_if #(.RAS_WIDTH(RW), .TAG_W(TW), .CNT_W(CW)) bus();
  du_ras_ctrl #(.RAS_WIDTH(RW), .PRED_DEPTH(PD), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int compared = 0;
  int mismatched = 0;

  // Reference model: the prediction table as plain arrays.
  bit          m_busy [PD];
  logic [31:0] m_tgt  [PD];
  int          m_ptr;
  bit          m_flush;
  logic [31:0] m_ft;
  int          m_cnt;
  bit          m_ok = 0;
  bit          last_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit f_jr();
    return bus.if_valid === 1'b1 && bus.if_is_jr31 === 1'b1 && bus.if_is_jal !== 1'b1;
  endfunction
  function automatic bit f_stall();
    return !reset && (m_flush || (f_jr() && m_busy[m_ptr]));
  endfunction
  function automatic bit f_acc();
    return bus.if_valid === 1'b1 && !f_stall() && !reset;
  endfunction
  function automatic int f_pend();
    int n = 0;
    for (int i = 0; i < PD; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic upd();
    bit pop, hit, mis;
    int t;
    if (reset) begin
      for (int i = 0; i < PD; i++) m_busy[i] = 0;
      m_ptr = 0; m_flush = 0; m_ft = 0; m_cnt = 0; m_ok = 1;
      return;
    end
    if (!m_ok) return;
    pop = f_acc() && f_jr();
    t   = int'(bus.cdb_jr31_tag);
    hit = bus.cdb_jr31_valid && m_busy[t] && !m_flush;
    mis = hit && (bus.cdb_jr31_target != m_tgt[t]);
    m_flush = mis;
    if (mis) begin
      m_ft = bus.cdb_jr31_target;
      if (m_cnt < CMAX) m_cnt++;
      for (int i = 0; i < PD; i++) m_busy[i] = 0;
      m_ptr = 0;
    end else begin
      if (pop) begin
        m_busy[m_ptr] = 1;
        m_tgt[m_ptr]  = bus.du_jr31_pop_dout;
        m_ptr = (m_ptr + 1) % PD;
      end
      if (hit) m_busy[t] = 0;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    logic [31:0] e_din;
    bit acc, stl;
    if (m_ok) begin
      stl = f_stall();
      acc = f_acc();
      e_din = bus.if_pc + 32'd4;
      chk("stall", bus.du_stall, stl);
      chk("push", bus.du_jal_push, acc && bus.if_is_jal);
      if (acc && bus.if_is_jal) chk("push_din", bus.du_jal_push_din, e_din);
      chk("pop", bus.du_jr31_pop, acc && f_jr());
      chk("pred_valid", bus.du_jr31_pred_valid, acc && f_jr());
      if (acc && f_jr()) begin
        chk("pred_target", bus.du_jr31_pred_target, bus.du_jr31_pop_dout);
        chk("pred_tag", bus.du_jr31_pred_tag, m_ptr);
      end
      chk("flush", bus.du_flush, m_flush);
      if (m_flush) chk("flush_target", bus.du_flush_target, m_ft);
      chk("pending_cnt", bus.du_pending_cnt, f_pend());
      chk("mispred_cnt", bus.du_mispred_cnt, m_cnt);
      last_stall = stl;
    end
  end

  task automatic drv(input bit v, input logic [31:0] pc, input bit jal, input bit jr,
                     input logic [31:0] dout, input bit cv, input logic [1:0] tag,
                     input logic [31:0] ct);
    bus.if_valid = v; bus.if_pc = pc; bus.if_is_jal = jal; bus.if_is_jr31 = jr;
    bus.du_jr31_pop_dout = dout;
    bus.cdb_jr31_valid = cv; bus.cdb_jr31_tag = tag; bus.cdb_jr31_target = ct;
  endtask

  task automatic tick();
    @(posedge clk);
    upd();
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit v, jal, jr, cv;
    logic [31:0] pc, dout, ct;
    logic [1:0] tag;
    int r;
    for (int i = 0; i < PD; i++) m_tgt[i] = 32'h0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    repeat (3) tick();
    reset = 0;

    // jal pushes pc+4, including the wrap case
    drv(1, 32'h100, 1, 0, 0, 0, 0, 0); mid();
    chk("t1_push", bus.du_jal_push, 1); chk("t1_din", bus.du_jal_push_din, 32'h104);
    chk("t1_pop", bus.du_jr31_pop, 0);  chk("t1_stall", bus.du_stall, 0);
    tick();
    drv(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0); mid();
    chk("t2_din_wrap", bus.du_jal_push_din, 32'h0);
    tick();

    // four jr $31 fill the table, fifth stalls
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h200 + i * 4, 0, 1, 32'h104, 0, 0, 0); mid();
      chk("t3_pop", bus.du_jr31_pop, 1); chk("t3_tag", bus.du_jr31_pred_tag, i);
      tick();
    end
    drv(1, 32'h300, 0, 1, 32'h104, 0, 0, 0); mid();
    chk("t3_full_stall", bus.du_stall, 1); chk("t3_full_pop", bus.du_jr31_pop, 0);
    chk("t3_pend4", bus.du_pending_cnt, 4);
    tick();
    drv(1, 32'h300, 0, 1, 32'h104, 1, 0, 32'h104); mid();
    chk("t3_still_stall", bus.du_stall, 1);
    tick();
    drv(1, 32'h300, 0, 1, 32'h104, 0, 0, 0); mid();
    chk("t3_unstall", bus.du_stall, 0); chk("t3_pop5", bus.du_jr31_pop, 1);
    chk("t3_tag5", bus.du_jr31_pred_tag, 0);
    tick();

    // match on tag 1, then mismatch on tag 2
    drv(0, 0, 0, 0, 0, 1, 1, 32'h104); mid();
    chk("t4_pend4", bus.du_pending_cnt, 4);
    tick();
    drv(0, 0, 0, 0, 0, 1, 2, 32'h200); mid();
    chk("t4_pend3", bus.du_pending_cnt, 3); chk("t4_noflush", bus.du_flush, 0);
    tick();
    drv(1, 32'h500, 1, 0, 0, 1, 3, 32'h777); mid();
    chk("t4_flush", bus.du_flush, 1); chk("t4_ftgt", bus.du_flush_target, 32'h200);
    chk("t4_stall", bus.du_stall, 1); chk("t4_pend0", bus.du_pending_cnt, 0);
    chk("t4_cnt1", bus.du_mispred_cnt, 1); chk("t4_nopush", bus.du_jal_push, 0);
    tick();
    drv(1, 32'h600, 0, 1, 32'h44, 0, 0, 0); mid();
    chk("t4_flush_off", bus.du_flush, 0); chk("t4_ptr0", bus.du_jr31_pred_tag, 0);
    chk("t4_pop", bus.du_jr31_pop, 1);
    tick();

    // non-busy resolution ignored; jal+jr treated as jal
    reset = 1; drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); reset = 0;
    drv(0, 0, 0, 0, 0, 1, 3, 32'h5); mid(); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0); mid();
    chk("t5_pend0", bus.du_pending_cnt, 0); chk("t5_noflush", bus.du_flush, 0);
    tick();
    drv(1, 32'h40, 1, 1, 32'h77, 0, 0, 0); mid();
    chk("t5_push", bus.du_jal_push, 1); chk("t5_nopop", bus.du_jr31_pop, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0); mid();
    chk("t5_pend_same", bus.du_pending_cnt, 0);
    tick();

    // reset coinciding with a mismatch discards the flush
    drv(1, 32'h80, 0, 1, 32'h300, 0, 0, 0); mid(); tick();
    drv(0, 0, 0, 0, 0, 1, 0, 32'h999); reset = 1; mid(); tick(); reset = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0); mid();
    chk("t6_noflush", bus.du_flush, 0); chk("t6_cnt0", bus.du_mispred_cnt, 0);
    chk("t6_pend0", bus.du_pending_cnt, 0);
    tick();

    // randomized traffic; dispatch inputs are held while stalled
    v = 0; pc = 0; jal = 0; jr = 0; dout = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!last_stall) begin
        v  = ($urandom_range(0, 3) != 0);
        pc = $urandom;
        r  = $urandom_range(0, 9);
        jal = (r < 3) || (r == 7);
        jr  = (r >= 3 && r < 8);
        dout = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      end
      cv  = ($urandom_range(0, 2) == 0);
      tag = 2'($urandom_range(0, 3));
      ct  = ($urandom_range(0, 1) == 1) ? m_tgt[tag] : 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      drv(v, pc, jal, jr, dout, cv, tag, ct);
      tick();
    end
    reset = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
